// File: rtl/conc_pkg.sv
// Shared types for the concolic stimulus sequencer: FSM states, opcode bit
// positions and the per-step trace record.
package conc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int OP_L1  = 0;
  localparam int OP_L2  = 1;
  localparam int OP_OBS = 2;

  typedef struct packed {
    logic outp;
    logic overflw;
  } trace_rec_t;

endpackage

// File: rtl/conc_op_ram.sv
// Opcode memory: DEPTH x OP_W, one synchronous write port, one asynchronous
// read port. Contents are not reset; out-of-range writes are dropped.
module conc_op_ram #(
  parameter int OP_W   = 3,
  parameter int DEPTH  = 11,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [OP_W-1:0]   wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [OP_W-1:0]   rdata_o
);

  logic [OP_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i && (int'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/conc_stim_sequencer.sv
// Replays the opcode memory onto the b01 inputs one opcode per clock and
// records the {outp,overflw} response for every step as a trace beat.
module conc_stim_sequencer
  import conc_pkg::*;
#(
  parameter int OP_W     = 3,
  parameter int DEPTH    = 11,
  parameter int ADDR_W   = 4,
  parameter int STOP_OVF = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [OP_W-1:0]   load_data,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] steps,
  output logic              line1,
  output logic              line2,
  output logic              obs,
  input  logic              dut_outp,
  input  logic              dut_overflw,
  output logic              trace_valid,
  output logic [ADDR_W-1:0] trace_idx,
  output logic [1:0]        trace_data
);

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] steps_q;
  logic              busy_q;
  logic              done_q;
  logic              aborted_q;
  logic              drain_q;
  logic [OP_W-1:0]   pins_q;
  logic [ADDR_W-1:0] idx_p0_q;
  logic              vld_p0_q;
  logic              trace_valid_q;
  logic [ADDR_W-1:0] trace_idx_q;
  trace_rec_t        trace_q;

  logic              ram_we;
  logic [OP_W-1:0]   ram_rdata;
  logic              ovf_stop;

  assign ram_we = load_we && (state_q == IDLE);

  conc_op_ram #(
    .OP_W   (OP_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_op_ram (
    .clock   (clock),
    .we_i    (ram_we),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (pc_q),
    .rdata_o (ram_rdata)
  );

  assign ovf_stop = (STOP_OVF != 0) && trace_valid_q && trace_q.overflw;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      steps_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      drain_q       <= 1'b0;
      pins_q        <= '0;
      idx_p0_q      <= '0;
      vld_p0_q      <= 1'b0;
      trace_valid_q <= 1'b0;
      trace_idx_q   <= '0;
      trace_q       <= '0;
    end else begin
      done_q        <= 1'b0;
      vld_p0_q      <= 1'b0;
      // Stage p1: the response to the opcode issued last cycle is on the b01 outputs now.
      trace_valid_q <= vld_p0_q;
      trace_idx_q   <= idx_p0_q;
      trace_q       <= '{outp: dut_outp, overflw: dut_overflw};

      case (state_q)
        IDLE: begin
          if (start) begin
            pc_q      <= '0;
            steps_q   <= '0;
            busy_q    <= 1'b1;
            aborted_q <= 1'b0;
            state_q   <= RUN;
          end
        end

        RUN, DRAIN: begin
          if (abort || ovf_stop) begin
            // Early end: in-flight opcodes are discarded, nothing more is traced.
            state_q       <= DONE;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            aborted_q     <= 1'b1;
            pins_q        <= '0;
            trace_valid_q <= 1'b0;
          end else if (state_q == RUN) begin
            // Stage p0: issue mem[pc] onto the pins and tag it with its step index.
            pins_q   <= ram_rdata;
            idx_p0_q <= pc_q;
            vld_p0_q <= 1'b1;
            steps_q  <= steps_q + ADDR_W'(1);
            if (pc_q == ADDR_W'(DEPTH - 1)) begin
              drain_q <= 1'b0;
              state_q <= DRAIN;
            end else begin
              pc_q <= pc_q + ADDR_W'(1);
            end
          end else if (drain_q) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= 1'b0;
            pins_q    <= '0;
          end else begin
            drain_q <= 1'b1;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign steps       = steps_q;
  assign line1       = pins_q[OP_L1];
  assign line2       = pins_q[OP_L2];
  assign obs         = pins_q[OP_OBS];
  assign trace_valid = trace_valid_q;
  assign trace_idx   = trace_idx_q;
  assign trace_data  = trace_q;

endmodule

// File: tb/tb_conc_stim_sequencer.sv
// Bench for conc_stim_sequencer: a STOP_OVF=0 and a STOP_OVF=1 instance share
// the load/run inputs; each drives its own combinational b01 response model.
module tb_conc_stim_sequencer;

  localparam int D = 11;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       load_we = 1'b0;
  logic [3:0] load_addr = '0;
  logic [2:0] load_data = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;

  logic       busy0, done0, aborted0, l1_0, l2_0, obs0, outp0, ovf0, tv0;
  logic [3:0] steps0, tidx0;
  logic [1:0] tdata0;
  logic       busy1, done1, aborted1, l1_1, l2_1, obs1, outp1, ovf1, tv1;
  logic [3:0] steps1, tidx1;
  logic [1:0] tdata1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] ref_mem [D];
  logic [5:0] q0 [$];
  logic [5:0] q1 [$];

  always #5 clock = ~clock;

  // b01 response model: outp is the parity of the opcode, overflw fires on opcode 3'b111.
  function automatic logic [1:0] resp(input logic [2:0] op);
    return {^op, &op};
  endfunction

  assign outp0 = ^{obs0, l2_0, l1_0};
  assign ovf0  = &{obs0, l2_0, l1_0};
  assign outp1 = ^{obs1, l2_1, l1_1};
  assign ovf1  = &{obs1, l2_1, l1_1};

  conc_stim_sequencer #(.OP_W(3), .DEPTH(D), .ADDR_W(4), .STOP_OVF(0)) u_dut (
    .clock(clock), .reset_n(reset_n), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .start(start), .abort(abort), .busy(busy0), .done(done0),
    .aborted(aborted0), .steps(steps0), .line1(l1_0), .line2(l2_0), .obs(obs0),
    .dut_outp(outp0), .dut_overflw(ovf0), .trace_valid(tv0), .trace_idx(tidx0),
    .trace_data(tdata0)
  );

  conc_stim_sequencer #(.OP_W(3), .DEPTH(D), .ADDR_W(4), .STOP_OVF(1)) u_dut_ovf (
    .clock(clock), .reset_n(reset_n), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .start(start), .abort(abort), .busy(busy1), .done(done1),
    .aborted(aborted1), .steps(steps1), .line1(l1_1), .line2(l2_1), .obs(obs1),
    .dut_outp(outp1), .dut_overflw(ovf1), .trace_valid(tv1), .trace_idx(tidx1),
    .trace_data(tdata1)
  );

  always @(posedge clock) begin
    #1;
    if (tv0) q0.push_back({tidx0, tdata0});
    if (tv1) q1.push_back({tidx1, tdata1});
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_word(input logic [3:0] a, input logic [2:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(posedge clock); #1;
    load_we = 1'b0;
    if (a < 4'(D)) ref_mem[a] = d;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic run_full(input string tag);
    q0.delete();
    do_start();
    for (int k = 0; k < D; k++) begin
      @(posedge clock); #1;
      n_checks++;
      if ({obs0, l2_0, l1_0} !== ref_mem[k] || busy0 !== 1'b1) begin
        n_fail++;
        $display("FAIL %s pins step %0d: got %b busy %b, want %b busy 1", tag, k, {obs0, l2_0, l1_0}, busy0, ref_mem[k]);
      end
    end
    @(posedge clock); #1;
    n_checks++;
    if (tv0 !== 1'b1 || tidx0 !== 4'(D - 1) || done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s final beat: tv %b idx %0d done %b, want tv 1 idx %0d done 0", tag, tv0, tidx0, done0, D - 1);
    end
    @(posedge clock); #1;
    n_checks++;
    if (done0 !== 1'b1 || aborted0 !== 1'b0 || steps0 !== 4'(D) || busy0 !== 1'b0 || {obs0, l2_0, l1_0} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s end: done %b aborted %b steps %0d busy %b pins %b, want 1 0 %0d 0 000", tag, done0, aborted0, steps0, busy0, {obs0, l2_0, l1_0}, D);
    end
    n_checks++;
    if (q0.size() != D) begin
      n_fail++;
      $display("FAIL %s beat count: got %0d, want %0d", tag, q0.size(), D);
    end else begin
      for (int i = 0; i < D; i++) begin
        n_checks++;
        if (q0[i] !== {4'(i), resp(ref_mem[i])}) begin
          n_fail++;
          $display("FAIL %s beat %0d: got %h, want %h", tag, i, q0[i], {4'(i), resp(ref_mem[i])});
        end
      end
    end
    @(posedge clock); #1;
    n_checks++;
    if (done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done width: done still %b one cycle later, want 0", tag, done0);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({busy0, done0, l1_0, l2_0, obs0, tv0, aborted0} !== 7'b0 || steps0 !== 4'd0 ||
        {busy1, done1, l1_1, l2_1, obs1, tv1, aborted1} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset outputs: dut0 %b steps %0d dut1 %b, want all 0",
               {busy0, done0, l1_0, l2_0, obs0, tv0, aborted0}, steps0, {busy1, done1, l1_1, l2_1, obs1, tv1, aborted1});
    end
    start = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset release: busy %b done %b, want 0 0", busy0, done0);
    end
  endtask

  task automatic test_pattern();
    for (int a = 0; a < D; a++) write_word(4'(a), 3'(a % 8));
    run_full("pattern");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < D; a++) write_word(4'(a), 3'($urandom_range(0, 7)));
      write_word(4'($urandom_range(D, 15)), 3'($urandom_range(0, 7)));
      run_full("random");
    end
  endtask

  task automatic test_abort();
    q0.delete();
    do_start();
    repeat (4) @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    n_checks++;
    if (done0 !== 1'b1 || aborted0 !== 1'b1 || steps0 !== 4'd4 || {obs0, l2_0, l1_0} !== 3'b000 || tv0 !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort end: done %b aborted %b steps %0d pins %b tv %b busy %b, want 1 1 4 000 0 0",
               done0, aborted0, steps0, {obs0, l2_0, l1_0}, tv0, busy0);
    end
    repeat (5) @(posedge clock);
    #1;
    n_checks++;
    if (q0.size() != 3 || done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort trace: got %0d beats done %b, want 3 beats done 0", q0.size(), done0);
    end
  endtask

  task automatic test_stop_ovf();
    for (int a = 0; a < D; a++) write_word(4'(a), (a == 5) ? 3'b111 : 3'($urandom_range(0, 6)));
    q1.delete();
    do_start();
    for (int c = 1; c <= D + 3; c++) begin
      @(posedge clock); #1;
      if (c == 7) begin
        n_checks++;
        if (tv1 !== 1'b1 || tidx1 !== 4'd5 || tdata1[0] !== 1'b1 || done1 !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf beat: tv %b idx %0d data %b done %b, want 1 5 x1 0", tv1, tidx1, tdata1, done1);
        end
      end
      if (c == 8) begin
        n_checks++;
        if (done1 !== 1'b1 || aborted1 !== 1'b1 || tv1 !== 1'b0 || steps1 !== 4'd7 || {obs1, l2_1, l1_1} !== 3'b000) begin
          n_fail++;
          $display("FAIL ovf stop: done %b aborted %b tv %b steps %0d pins %b, want 1 1 0 7 000",
                   done1, aborted1, tv1, steps1, {obs1, l2_1, l1_1});
        end
      end
    end
    n_checks++;
    if (q1.size() != 6) begin
      n_fail++;
      $display("FAIL ovf beat count: got %0d, want 6", q1.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (q1[i] !== {4'(i), resp(ref_mem[i])}) begin
          n_fail++;
          $display("FAIL ovf beat %0d: got %h, want %h", i, q1[i], {4'(i), resp(ref_mem[i])});
        end
      end
    end
  endtask

  task automatic test_start_collision();
    int n_done = 0;
    load_we = 1'b1; load_addr = 4'd0; load_data = 3'b011; start = 1'b1;
    @(posedge clock); #1;
    load_we = 1'b0; start = 1'b0;
    ref_mem[0] = 3'b011;
    @(posedge clock); #1;
    n_checks++;
    if ({obs0, l2_0, l1_0} !== 3'b011) begin
      n_fail++;
      $display("FAIL collision first opcode: got %b, want 011", {obs0, l2_0, l1_0});
    end
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clock); #1;
      if (done0) n_done++;
    end
    n_checks++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL busy start: got %0d done pulses, want 1", n_done);
    end
  endtask

  task automatic test_bound_and_reset();
    write_word(4'd12, ~ref_mem[2]);
    run_full("bound");
    do_start();
    repeat (D) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy0, done0, aborted0, l1_0, l2_0, obs0, tv0} !== 7'b0 || steps0 !== 4'd0 || tidx0 !== 4'd0) begin
      n_fail++;
      $display("FAIL drain reset: flags %b steps %0d idx %0d, want all 0",
               {busy0, done0, aborted0, l1_0, l2_0, obs0, tv0}, steps0, tidx0);
    end
    @(negedge clock); reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      n_checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0 || tv0 !== 1'b0) begin
        n_fail++;
        $display("FAIL after reset cycle %0d: busy %b done %b tv %b, want 0 0 0", c, busy0, done0, tv0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_random();
    test_abort();
    test_stop_ovf();
    test_start_collision();
    test_bound_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
